rsa_sector_scheduler: RTL and testbench

- Job controller in front of rsa_asip_system.
- Accepts one command: algorithm select plus an inclusive sector range.
- For each sector in the range: drives selected/sector_select, issues a one-cycle start pulse, waits for the rising edge of reg15, then captures the fixed-length gpio byte stream and forwards it tagged with sector number and last-byte marker.
- Sits between host/bench command logic and the ASIP; owns all start/sector sequencing.

---
 rtl/rsa_ctrl_pkg.sv | 28 ++
 rtl/rsa_stream_counter.sv | 60 ++++++
 rtl/rsa_sector_scheduler.sv | 144 ++++++++++++++
 tb/tb_rsa_sector_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_ctrl_pkg.sv
// Shared widths, defaults and types for the RSA sector scheduler.
package rsa_ctrl_pkg;

    localparam int unsigned SECTOR_W     = 4;
    localparam int unsigned BYTE_CNT_W   = 17;
    localparam int unsigned TMO_W        = 24;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned DONE_CNT_W   = 5;

    localparam int unsigned DEF_LEN_ALG0 = 40000;
    localparam int unsigned DEF_LEN_ALG1 = 88804;
    localparam int unsigned DEF_TIMEOUT  = 16777215;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        STREAM    = 3'd3,
        ADVANCE   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [SECTOR_W-1:0] sector;
        logic                last;
    } out_beat_t;

endpackage

// File: rtl/rsa_stream_counter.sv
// Per-sector byte counter plus the one-cycle registered output stage.
module rsa_stream_counter
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned LEN_ALG0 = DEF_LEN_ALG0,
    parameter int unsigned LEN_ALG1 = DEF_LEN_ALG1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                len_sel,
    input  logic                capture,
    input  logic [DATA_W-1:0]   data,
    input  logic [SECTOR_W-1:0] sector,
    output logic                last_c,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [SECTOR_W-1:0] out_sector,
    output logic                out_last
);

    logic [BYTE_CNT_W-1:0] cnt;
    logic [BYTE_CNT_W-1:0] idx;
    logic [BYTE_CNT_W-1:0] len_m1;
    out_beat_t             beat_q;
    logic                  valid_q;

    assign len_m1 = len_sel ? BYTE_CNT_W'(LEN_ALG1 - 1) : BYTE_CNT_W'(LEN_ALG0 - 1);
    // The load cycle itself carries byte 0, so index it as zero there.
    assign idx    = load ? '0 : cnt;
    assign last_c = (idx == len_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= capture;
            if (load) begin
                cnt <= BYTE_CNT_W'(1);
            end else if (capture) begin
                cnt <= cnt + BYTE_CNT_W'(1);
            end
            if (capture) begin
                beat_q.data   <= data;
                beat_q.sector <= sector;
                beat_q.last   <= last_c;
            end else begin
                beat_q.last   <= 1'b0;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = beat_q.data;
    assign out_sector = beat_q.sector;
    assign out_last   = beat_q.last;

endmodule

// File: rtl/rsa_sector_scheduler.sv
// Job controller in front of the RSA ASIP: sequences start/sector per job and
// forwards each sector's gpio byte stream tagged with sector and last marker.
module rsa_sector_scheduler
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned LEN_ALG0 = DEF_LEN_ALG0,
    parameter int unsigned LEN_ALG1 = DEF_LEN_ALG1,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_alg,
    input  logic [SECTOR_W-1:0]   cmd_first,
    input  logic [SECTOR_W-1:0]   cmd_last,
    output logic                  asip_selected,
    output logic [SECTOR_W-1:0]   asip_sector,
    output logic                  asip_start,
    input  logic                  asip_done,
    input  logic [DATA_W-1:0]     asip_data,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [SECTOR_W-1:0]   out_sector,
    output logic                  out_last,
    output logic                  busy,
    output logic                  job_done,
    output logic                  err_timeout,
    output logic [DONE_CNT_W-1:0] sectors_done
);

    sched_state_t        state;
    logic [SECTOR_W-1:0] cur;
    logic [SECTOR_W-1:0] last_q;
    logic                alg_q;
    logic [TMO_W-1:0]    tmo;
    logic                done_q;
    logic                done_rise;
    logic                load;
    logic                capture;
    logic                last_c;

    // Only a fresh 0->1 on reg15 counts; a level left over from the last sector does not.
    assign done_rise = asip_done & ~done_q;
    assign load      = (state == WAIT_DONE) && done_rise;
    assign capture   = load || (state == STREAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            last_q       <= '0;
            alg_q        <= 1'b0;
            tmo          <= '0;
            done_q       <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            asip_start   <= 1'b0;
            job_done     <= 1'b0;
            err_timeout  <= 1'b0;
            sectors_done <= '0;
        end else begin
            done_q     <= asip_done;
            asip_start <= 1'b0;
            job_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alg_q        <= cmd_alg;
                        cur          <= cmd_first;
                        last_q       <= cmd_last;
                        err_timeout  <= 1'b0;
                        sectors_done <= '0;
                        asip_start   <= 1'b1;
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    tmo   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A rising edge beats an expiring timeout in the same cycle.
                    if (done_rise) begin
                        state <= last_c ? ADVANCE : STREAM;
                    end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        job_done    <= 1'b1;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                STREAM: begin
                    if (last_c) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    sectors_done <= sectors_done + DONE_CNT_W'(1);
                    if (cur == last_q) begin
                        job_done  <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cur        <= cur + SECTOR_W'(1);
                        asip_start <= 1'b1;
                        state      <= START;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign asip_selected = alg_q;
    assign asip_sector   = cur;

    rsa_stream_counter #(
        .LEN_ALG0 (LEN_ALG0),
        .LEN_ALG1 (LEN_ALG1)
    ) u_stream (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .len_sel    (alg_q),
        .capture    (capture),
        .data       (asip_data),
        .sector     (cur),
        .last_c     (last_c),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sector (out_sector),
        .out_last   (out_last)
    );

endmodule

// File: tb/tb_rsa_sector_scheduler.sv
// Bench for rsa_sector_scheduler: job table plus ASIP model and byte scoreboard.
module tb_rsa_sector_scheduler;

    localparam int L0     = 40;
    localparam int L1     = 88;
    localparam int TMO    = 100;
    localparam int DELAY  = 20;
    localparam int LIMIT  = 3000;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_HOLD   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_alg;
    logic [3:0] cmd_first;
    logic [3:0] cmd_last;
    logic       asip_selected;
    logic [3:0] asip_sector;
    logic       asip_start;
    logic       asip_done;
    logic [7:0] asip_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_sector;
    logic       out_last;
    logic       busy;
    logic       job_done;
    logic       err_timeout;
    logic [4:0] sectors_done;

    rsa_sector_scheduler #(
        .LEN_ALG0 (L0),
        .LEN_ALG1 (L1),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_alg       (cmd_alg),
        .cmd_first     (cmd_first),
        .cmd_last      (cmd_last),
        .asip_selected (asip_selected),
        .asip_sector   (asip_sector),
        .asip_start    (asip_start),
        .asip_done     (asip_done),
        .asip_data     (asip_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_sector    (out_sector),
        .out_last      (out_last),
        .busy          (busy),
        .job_done      (job_done),
        .err_timeout   (err_timeout),
        .sectors_done  (sectors_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] sector;
        logic       last;
    } exp_t;

    typedef struct {
        int alg;
        int first;
        int last;
        int mode;
        int poke;
        int exp_sec;
        int exp_err;
    } job_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   model_mode = M_NORMAL;
    int   cur_len = L0;
    int   run_len = 0;
    int   last_cyc = 0;
    bit   mon_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_outputs_zero",
            32'({asip_selected, asip_sector, asip_start, out_valid, out_data, out_sector,
                 out_last, busy, job_done, err_timeout, sectors_done}), 32'd0);
    endtask

    // ASIP model: reg15 rises DELAY cycles after start; gpio carries byte index.
    initial begin
        asip_done = 1'b0;
        asip_data = 8'd0;
        forever begin
            @(negedge clk);
            if (asip_start && model_mode != M_NEVER) begin
                int n;
                n = asip_selected ? L1 : L0;
                if (model_mode == M_HOLD && asip_done) begin
                    repeat (5) @(negedge clk);
                    asip_done = 1'b0;
                    repeat (3) @(negedge clk);
                end else begin
                    asip_done = 1'b0;
                    repeat (DELAY) @(negedge clk);
                end
                asip_done = 1'b1;
                asip_data = 8'd0;
                for (int i = 1; i < n; i++) begin
                    @(negedge clk);
                    asip_data = 8'(i);
                    if (model_mode != M_HOLD && i == 2) asip_done = 1'b0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard and checks per-sector run length.
    always @(negedge clk) begin
        if (mon_hold) begin
            run_len = 0;
        end else if (out_valid) begin
            run_len++;
            if (out_last) last_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", {19'd0, out_data, out_sector, out_last}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_beat", {19'd0, out_data, out_sector, out_last}, {19'd0, e});
            end
        end else if (run_len > 0) begin
            chk("run_length", 32'(run_len), 32'(cur_len));
            run_len = 0;
        end
    end

    task automatic run_job(input job_t j);
        int  n;
        int  nsec;
        int  starts;
        int  start_cyc;
        int  done_cyc;
        bit  got;
        n       = (j.alg != 0) ? L1 : L0;
        nsec    = ((j.last - j.first + 16) % 16) + 1;
        cur_len = n;
        model_mode = j.mode;
        if (j.mode != M_NEVER) begin
            for (int k = 0; k < nsec; k++) begin
                for (int b = 0; b < n; b++) begin
                    exp_q.push_back('{data: 8'(b), sector: 4'((j.first + k) % 16), last: (b == n - 1)});
                end
            end
        end
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_alg   = (j.alg != 0);
        cmd_first = 4'(j.first);
        cmd_last  = 4'(j.last);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept_state", 32'({busy, cmd_ready, err_timeout, sectors_done}), 32'({1'b1, 1'b0, 1'b0, 5'd0}));
        starts = 0; start_cyc = 0; done_cyc = 0; got = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            if (c > 0) @(negedge clk);
            if (asip_start) begin
                chk("start_sector", 32'({asip_selected, asip_sector}),
                    32'({(j.alg != 0), 4'((j.first + starts) % 16)}));
                starts++;
                start_cyc = cyc;
            end
            if (j.poke != 0 && c == j.poke) begin
                chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
                cmd_valid = 1'b1;
                cmd_alg   = (j.alg == 0);
                cmd_first = 4'(j.first + 8);
                cmd_last  = 4'(j.first + 8);
            end
            if (j.poke != 0 && c == j.poke + 1) cmd_valid = 1'b0;
            if (job_done) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk("job_done_seen", 32'(got), 32'd1);
        chk("sectors_done", 32'(sectors_done), 32'(j.exp_sec));
        chk("err_timeout", 32'(err_timeout), 32'(j.exp_err));
        chk("end_ready_busy", 32'({cmd_ready, busy}), 32'({1'b1, 1'b0}));
        chk("start_count", 32'(starts), 32'((j.mode == M_NEVER) ? 1 : nsec));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (j.mode == M_NEVER) chk("timeout_latency", 32'(done_cyc - start_cyc), 32'(TMO + 1));
        else chk("job_done_after_last", 32'(done_cyc - last_cyc), 32'd1);
        @(negedge clk);
        chk("job_done_pulse", 32'(job_done), 32'd0);
        exp_q.delete();
    endtask

    job_t jobs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        jobs[0] = '{alg: 0, first: 2,  last: 2, mode: M_NORMAL, poke: 0,  exp_sec: 1,  exp_err: 0};
        jobs[1] = '{alg: 1, first: 14, last: 0, mode: M_NORMAL, poke: 0,  exp_sec: 3,  exp_err: 0};
        jobs[2] = '{alg: 0, first: 5,  last: 5, mode: M_NEVER,  poke: 0,  exp_sec: 0,  exp_err: 1};
        jobs[3] = '{alg: 0, first: 3,  last: 4, mode: M_HOLD,   poke: 0,  exp_sec: 2,  exp_err: 0};
        jobs[4] = '{alg: 0, first: 9,  last: 9, mode: M_NORMAL, poke: 40, exp_sec: 1,  exp_err: 0};
        jobs[5] = '{alg: 0, first: 6,  last: 5, mode: M_NORMAL, poke: 0,  exp_sec: 16, exp_err: 0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_alg   = 1'b0;
        cmd_first = 4'd0;
        cmd_last  = 4'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            run_job(jobs[t]);
            repeat (3) @(negedge clk);
        end

        // One-cycle reset in the middle of a stream.
        mon_hold   = 1'b1;
        model_mode = M_NORMAL;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_alg   = 1'b0;
        cmd_first = 4'd5;
        cmd_last  = 4'd6;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 100 && !out_valid; c++) @(negedge clk);
        chk("reset_seq_streaming", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        begin
            bit jd;
            jd = 1'b0;
            repeat (70) begin
                @(negedge clk);
                jd = jd | job_done | out_valid;
            end
            chk("quiet_after_reset", 32'(jd), 32'd0);
        end
        mon_hold = 1'b0;
        run_job('{alg: 0, first: 7, last: 7, mode: M_NORMAL, poke: 0, exp_sec: 1, exp_err: 0});

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
